// File: rtl/ah_decoder_range_ctrl.sv
// ah_decoder_range_ctrl: sequencing and configuration controller for the AH
// address-range decoder. Holds per-client bottom/top-of-memory bounds and an
// enable bit, accepts one ingress request at a time, decodes it against the
// enabled ranges with fixed lowest-index priority, then either issues it to the
// winning client or pulses a decode error.
//
// Optional feature macro: AH_DEC_ERR_CNT_EN
//   defined   -> o_err_cnt is an 8-bit saturating decode-error counter
//   undefined -> o_err_cnt is tied to zero and no counter flops exist
module ah_decoder_range_ctrl #(
  parameter int unsigned ADDR_W      = 34,
  parameter int unsigned NUM_CLIENTS = 8,
  parameter int unsigned CLI_W       = 3
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_cfg_wr_en,
  input  logic [CLI_W-1:0]       i_cfg_idx,
  input  logic [1:0]             i_cfg_sel,
  input  logic [ADDR_W-1:0]      i_cfg_wdata,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic [ADDR_W-1:0]      i_ingress_pkt_field,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic [CLI_W-1:0]       o_out_client,
  output logic [NUM_CLIENTS-1:0] o_decoded_binary,
  output logic [ADDR_W-1:0]      o_out_addr,
  output logic                   o_dec_err,
  output logic [7:0]             o_err_cnt
);

  typedef enum logic [1:0] {
    StIdle,
    StDecode,
    StIssue,
    StErr
  } state_e;

  state_e r_state;
  state_e w_state_nxt;

  // Range configuration registers
  logic [ADDR_W-1:0]      r_bom [NUM_CLIENTS];
  logic [ADDR_W-1:0]      r_tom [NUM_CLIENTS];
  logic [NUM_CLIENTS-1:0] r_en;

  // Captured request and decode result
  logic [ADDR_W-1:0]      r_addr;
  logic [CLI_W-1:0]       r_client;
  logic [NUM_CLIENTS-1:0] r_onehot;

  // Decode signals
  logic [NUM_CLIENTS-1:0] w_match;
  logic                   w_hit;
  logic [CLI_W-1:0]       w_win;
  logic [NUM_CLIENTS-1:0] w_win_oh;

  // Per-client inclusive range compare; an inverted range (bom > tom) never matches
  always_comb begin
    w_match = '0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      w_match[i] = r_en[i] && (r_bom[i] <= r_addr) && (r_addr <= r_tom[i]);
    end
  end

  // Lowest-index priority select: scan downwards so the lowest match is written last
  always_comb begin
    w_hit    = |w_match;
    w_win    = '0;
    w_win_oh = '0;
    for (int i = int'(NUM_CLIENTS) - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_win       = CLI_W'(i);
        w_win_oh    = '0;
        w_win_oh[i] = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:   if (i_in_valid) w_state_nxt = StDecode;
      StDecode: w_state_nxt = w_hit ? StIssue : StErr;
      StIssue:  if (i_out_ready) w_state_nxt = StIdle;
      StErr:    w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  // Request capture and decode-result registers; held stable through ISSUE
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_addr   <= '0;
      r_client <= '0;
      r_onehot <= '0;
    end else begin
      if (r_state == StIdle && i_in_valid) begin
        r_addr <= i_ingress_pkt_field;
      end
      if (r_state == StDecode && w_hit) begin
        r_client <= w_win;
        r_onehot <= w_win_oh;
      end
    end
  end

  // Config writes, accepted in every state; out-of-range indices are dropped
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_bom <= '{default: '0};
      r_tom <= '{default: '0};
      r_en  <= '0;
    end else if (i_cfg_wr_en) begin
      for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
        if (i_cfg_idx == CLI_W'(i)) begin
          case (i_cfg_sel)
            2'd0:    r_bom[i] <= i_cfg_wdata;
            2'd1:    r_tom[i] <= i_cfg_wdata;
            2'd2:    r_en[i]  <= i_cfg_wdata[0];
            default: ;
          endcase
        end
      end
    end
  end

`ifdef AH_DEC_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  // Saturating decode-error counter, cleared only by reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_err_cnt <= '0;
    end else if (r_state == StErr && r_err_cnt != 8'hFF) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign o_err_cnt = r_err_cnt;
`else
  assign o_err_cnt = '0;
`endif

  // Outputs decoded from state; in_ready is also gated while reset is held
  assign o_in_ready       = (r_state == StIdle) && i_rst_n;
  assign o_out_valid      = (r_state == StIssue);
  assign o_dec_err        = (r_state == StErr);
  assign o_decoded_binary = (r_state == StIssue) ? r_onehot : '0;
  assign o_out_client     = r_client;
  assign o_out_addr       = r_addr;

endmodule

// File: tb/tb_ah_decoder_range_ctrl.sv
// Self-checking bench for ah_decoder_range_ctrl. Inputs change on the falling
// edge, outputs are sampled on the falling edge. Expected responses come from
// a small range model and travel through a scoreboard queue.
module tb_ah_decoder_range_ctrl;

  localparam int unsigned ADDR_W      = 34;
  localparam int unsigned NUM_CLIENTS = 8;
  localparam int unsigned CLI_W       = 3;

  logic                   clk;
  logic                   rst_n;
  logic                   cfg_wr_en;
  logic [CLI_W-1:0]       cfg_idx;
  logic [1:0]             cfg_sel;
  logic [ADDR_W-1:0]      cfg_wdata;
  logic                   in_valid;
  logic                   in_ready;
  logic [ADDR_W-1:0]      pkt;
  logic                   out_valid;
  logic                   out_ready;
  logic [CLI_W-1:0]       out_client;
  logic [NUM_CLIENTS-1:0] decoded_binary;
  logic [ADDR_W-1:0]      out_addr;
  logic                   dec_err;
  logic [7:0]             err_cnt;

  ah_decoder_range_ctrl #(
    .ADDR_W      (ADDR_W),
    .NUM_CLIENTS (NUM_CLIENTS),
    .CLI_W       (CLI_W)
  ) u_dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_cfg_wr_en         (cfg_wr_en),
    .i_cfg_idx           (cfg_idx),
    .i_cfg_sel           (cfg_sel),
    .i_cfg_wdata         (cfg_wdata),
    .i_in_valid          (in_valid),
    .o_in_ready          (in_ready),
    .i_ingress_pkt_field (pkt),
    .o_out_valid         (out_valid),
    .i_out_ready         (out_ready),
    .o_out_client        (out_client),
    .o_decoded_binary    (decoded_binary),
    .o_out_addr          (out_addr),
    .o_dec_err           (dec_err),
    .o_err_cnt           (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit                     err;
    logic [CLI_W-1:0]       client;
    logic [NUM_CLIENTS-1:0] onehot;
    logic [ADDR_W-1:0]      addr;
  } exp_t;

  exp_t sb_q[$];

  int n_cmp;
  int n_bad;

  // Reference model state
  logic [ADDR_W-1:0]      m_bom [NUM_CLIENTS];
  logic [ADDR_W-1:0]      m_tom [NUM_CLIENTS];
  logic [NUM_CLIENTS-1:0] m_en;
  int                     m_err_cnt;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NUM_CLIENTS); i++) begin
      m_bom[i] = '0;
      m_tom[i] = '0;
    end
    m_en      = '0;
    m_err_cnt = 0;
  endtask

  task automatic model_write(input int idx, input logic [1:0] sel, input logic [ADDR_W-1:0] d);
    if (idx < int'(NUM_CLIENTS)) begin
      case (sel)
        2'd0:    m_bom[idx] = d;
        2'd1:    m_tom[idx] = d;
        2'd2:    m_en[idx]  = d[0];
        default: ;
      endcase
    end
  endtask

  function automatic exp_t model_decode(input logic [ADDR_W-1:0] a);
    exp_t e;
    e.err    = 1'b1;
    e.client = '0;
    e.onehot = '0;
    e.addr   = a;
    for (int i = 0; i < int'(NUM_CLIENTS); i++) begin
      if (e.err && m_en[i] && m_bom[i] <= a && a <= m_tom[i]) begin
        e.err       = 1'b0;
        e.client    = CLI_W'(i);
        e.onehot[i] = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic model_count_err();
`ifdef AH_DEC_ERR_CNT_EN
    if (m_err_cnt < 255) m_err_cnt++;
`endif
  endtask

  task automatic cfg_write(input int idx, input logic [1:0] sel, input logic [ADDR_W-1:0] d);
    cfg_wr_en = 1'b1;
    cfg_idx   = CLI_W'(idx);
    cfg_sel   = sel;
    cfg_wdata = d;
    @(negedge clk);
    cfg_wr_en = 1'b0;
    model_write(idx, sel, d);
  endtask

  task automatic program_range(input int idx, input logic [ADDR_W-1:0] bom,
                               input logic [ADDR_W-1:0] tom, input bit en);
    cfg_write(idx, 2'd0, bom);
    cfg_write(idx, 2'd1, tom);
    cfg_write(idx, 2'd2, ADDR_W'(en));
  endtask

  // Drive one request, optionally with a config write in the DECODE cycle.
  // Leaves the DUT in ISSUE when out_ready is low.
  task automatic send_req(input logic [ADDR_W-1:0] a, input bit late_wr, input int wi,
                          input logic [1:0] ws, input logic [ADDR_W-1:0] wd, output exp_t e);
    int t;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_eq("accept_wait_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    pkt      = a;
    sb_q.push_back(model_decode(a));
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("decode_in_ready", 64'(in_ready), 64'd0);
    if (late_wr) begin
      cfg_wr_en = 1'b1;
      cfg_idx   = CLI_W'(wi);
      cfg_sel   = ws;
      cfg_wdata = wd;
    end
    @(negedge clk);
    if (late_wr) begin
      cfg_wr_en = 1'b0;
      model_write(wi, ws, wd);
    end
    check_eq("sb_nonempty", 64'(sb_q.size() > 0), 64'd1);
    if (sb_q.size() == 0) begin
      e = model_decode(a);
      return;
    end
    e = sb_q.pop_front();
    check_eq("rsp_out_valid", 64'(out_valid), 64'(!e.err));
    check_eq("rsp_dec_err", 64'(dec_err), 64'(e.err));
    if (e.err) begin
      model_count_err();
      @(negedge clk);
      check_eq("err_pulse_one_cycle", 64'(dec_err), 64'd0);
      check_eq("err_no_out_valid", 64'(out_valid), 64'd0);
      check_eq("err_back_idle", 64'(in_ready), 64'd1);
      check_eq("err_cnt", 64'(err_cnt), 64'(m_err_cnt));
    end else begin
      check_eq("rsp_client", 64'(out_client), 64'(e.client));
      check_eq("rsp_onehot", 64'(decoded_binary), 64'(e.onehot));
      check_eq("rsp_addr", 64'(out_addr), 64'(e.addr));
      check_eq("issue_in_ready", 64'(in_ready), 64'd0);
      if (out_ready) begin
        @(negedge clk);
        check_eq("issue_done_valid", 64'(out_valid), 64'd0);
        check_eq("issue_done_onehot", 64'(decoded_binary), 64'd0);
        check_eq("issue_done_idle", 64'(in_ready), 64'd1);
      end
    end
  endtask

  task automatic req(input logic [ADDR_W-1:0] a);
    exp_t e;
    send_req(a, 1'b0, 0, 2'd0, '0, e);
  endtask

  initial begin
    exp_t e;
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    cfg_wr_en = 1'b0;
    cfg_idx   = '0;
    cfg_sel   = '0;
    cfg_wdata = '0;
    in_valid  = 1'b0;
    pkt       = '0;
    out_ready = 1'b1;
    model_reset();

    // Reset state while held
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready_held", 64'(in_ready), 64'd0);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_dec_err", 64'(dec_err), 64'd0);
    check_eq("rst_onehot", 64'(decoded_binary), 64'd0);
    check_eq("rst_client", 64'(out_client), 64'd0);
    check_eq("rst_addr", 64'(out_addr), 64'd0);
    check_eq("rst_err_cnt", 64'(err_cnt), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_release_in_ready", 64'(in_ready), 64'd1);

    // Unconfigured: everything errors
    req(34'h0_0000_1000);

    // Two adjacent ranges, inclusive boundaries
    program_range(0, 34'h1000, 34'h1FFF, 1'b1);
    program_range(1, 34'h2000, 34'h3FFF, 1'b1);
    req(34'h1FFF);
    req(34'h2000);
    req(34'h1000);
    req(34'h3FFF);
    req(34'h4000);
    req(34'h0FFF);
    req(34'h3_0000_2000);

    // Overlap: lowest index wins, then disable client0
    program_range(2, 34'h1800, 34'h2800, 1'b1);
    req(34'h1900);
    cfg_write(0, 2'd2, '0);
    req(34'h1900);
    cfg_write(5, 2'd3, 34'h1900);
    req(34'h1900);

    // A write landing in the DECODE cycle is not seen by that decode
    program_range(3, 34'h6000, 34'h6FFF, 1'b0);
    send_req(34'h6100, 1'b1, 3, 2'd2, 34'h1, e);
    req(34'h6100);

    // Backpressure with a config write to the issuing client during ISSUE
    out_ready = 1'b0;
    send_req(34'h2000, 1'b0, 0, 2'd0, '0, e);
    cfg_write(1, 2'd2, '0);
    for (int k = 0; k < 4; k++) begin
      check_eq("bp_out_valid", 64'(out_valid), 64'd1);
      check_eq("bp_client", 64'(out_client), 64'(e.client));
      check_eq("bp_onehot", 64'(decoded_binary), 64'(e.onehot));
      check_eq("bp_addr", 64'(out_addr), 64'(e.addr));
      check_eq("bp_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_release_valid", 64'(out_valid), 64'd0);
    check_eq("bp_release_idle", 64'(in_ready), 64'd1);
    // Next request accepted immediately; client1 now disabled so client2 wins
    req(34'h2000);

    // Inverted range never matches
    program_range(4, 34'h5000, 34'h4000, 1'b1);
    req(34'h4800);
    req(34'h5000);

    // Drive the error counter into saturation
    for (int k = 0; k < 300; k++) begin
      req(34'h0_0000_0100 + 34'(k));
    end
    check_eq("err_cnt_final", 64'(err_cnt), 64'(m_err_cnt));

    // Reset during a stalled ISSUE
    cfg_write(0, 2'd2, 34'h1);
    out_ready = 1'b0;
    send_req(34'h1100, 1'b0, 0, 2'd0, '0, e);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
    check_eq("midrst_onehot", 64'(decoded_binary), 64'd0);
    check_eq("midrst_client", 64'(out_client), 64'd0);
    check_eq("midrst_addr", 64'(out_addr), 64'd0);
    check_eq("midrst_err_cnt", 64'(err_cnt), 64'd0);
    check_eq("midrst_in_ready", 64'(in_ready), 64'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    model_reset();
    @(negedge clk);
    // All ranges disabled again
    req(34'h1100);
    req(34'h2000);
    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
